norm_block_scheduler: RTL and testbench

Sequencer for the HOG block-normalization datapath: it accepts 9-bin cell histograms from the cell stage, owns the 42-entry cell line-buffer RAM addressing, and for every complete 2x2 block drives the sum accumulator, bin selector and divider/sqrt pipeline with aligned strobes. It tracks cell position in the 40x30-cell frame and tags the 36 feature outputs of each block with a delayed valid and an end-of-frame marker.

---
 rtl/norm_block_scheduler.sv | 252 +++++++++++++++++++++++++
 tb/tb_norm_block_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_block_scheduler.sv
// norm_block_scheduler
// Sequencer for the HOG block-normalization datapath. Accepts 9-bin cell
// histograms, addresses the cell line-buffer RAM, and for each complete 2x2
// block issues 4 sum reads followed by 36 feature reads. Strobes that describe
// RAM read data are registered so they align with the 1-cycle read latency.
// The divider strobe is delayed by the div+sqrt pipeline depth to produce
// the feature valid and the end-of-frame marker.
//
// Ports:
//   clk, rst (async, active-low)
//   cell_valid, cell_sof       : incoming cell handshake, start-of-frame tag
//   cell_ready                 : scheduler idle, can accept a cell
//   wr_en, wr_addr             : line-buffer write of the accepted cell
//   rd_en, rd_addr             : line-buffer read of quad TL/TR/BL/BR
//   sum_ld, sum_acc            : sum register load / accumulate (data aligned)
//   div_go, q_sel, bin_sel     : divider sample strobe, quad and bin of data
//   o_valid, o_last            : feature output valid, final feature of frame
module norm_block_scheduler #(
    parameter int LINE     = 40,
    parameter int CELL_NUM = 1200,
    parameter int DEPTH    = 42,
    parameter int ADDR_W   = 6,
    parameter int PIPE_LAT = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cell_valid,
    input  logic              cell_sof,
    output logic              cell_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              sum_ld,
    output logic              sum_acc,
    output logic              div_go,
    output logic [1:0]        q_sel,
    output logic [3:0]        bin_sel,
    output logic              o_valid,
    output logic              o_last
);

    localparam int C_W   = $clog2(CELL_NUM);
    localparam int COL_W = $clog2(LINE);

    localparam logic [C_W-1:0]    C_LAST   = C_W'(CELL_NUM - 1);
    localparam logic [C_W-1:0]    C_LINE   = C_W'(LINE);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LINE - 1);
    localparam logic [ADDR_W-1:0] WP_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] OFF_TL   = ADDR_W'(LINE + 1);
    localparam logic [ADDR_W-1:0] OFF_TR   = ADDR_W'(LINE);
    localparam logic [ADDR_W-1:0] OFF_BL   = ADDR_W'(1);
    localparam logic [3:0]        BIN_LAST = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_FEAT = 2'd2
    } state_t;

    state_t state_r, state_n;
    logic [1:0]        q_r, q_n;
    logic [3:0]        bin_r, bin_n;
    logic [C_W-1:0]    c_r;
    logic [COL_W-1:0]  col_r;
    logic [ADDR_W-1:0] wp_r;
    logic [ADDR_W-1:0] blk_addr_r;
    logic              blk_last_r;

    logic              sum_ld_r, sum_acc_r, div_go_r, last_tag_r;
    logic [1:0]        q_sel_r;
    logic [3:0]        bin_sel_r;
    logic [PIPE_LAT-1:0] pipe_valid_r, pipe_last_r;

    logic              accept_s, block_s, rd_en_s;
    logic [C_W-1:0]    c_eff_s;
    logic [COL_W-1:0]  col_eff_s;
    logic [ADDR_W-1:0] a_eff_s, quad_addr_s;

    // Ring-buffer address d entries behind a, modulo DEPTH.
    function automatic logic [ADDR_W-1:0] addr_back(input logic [ADDR_W-1:0] a,
                                                    input logic [ADDR_W-1:0] d);
        logic [ADDR_W:0] t;
        if (a >= d) begin
            t = {1'b0, a} - {1'b0, d};
        end else begin
            t = {1'b0, a} + DEPTH_X - {1'b0, d};
        end
        return t[ADDR_W-1:0];
    endfunction

    // A start-of-frame cell restarts position tracking at cell 0 / address 0.
    assign c_eff_s   = cell_sof ? {C_W{1'b0}} : c_r;
    assign col_eff_s = cell_sof ? {COL_W{1'b0}} : col_r;
    assign a_eff_s   = cell_sof ? {ADDR_W{1'b0}} : wp_r;

    assign cell_ready = (state_r == ST_IDLE);
    assign accept_s   = cell_valid && cell_ready;
    // Block completes when the cell is not in row 0 and not in column 0.
    assign block_s    = (c_eff_s >= C_LINE) && (col_eff_s != {COL_W{1'b0}});
    assign rd_en_s    = (state_r != ST_IDLE);

    assign wr_en   = accept_s;
    assign wr_addr = a_eff_s;
    assign rd_en   = rd_en_s;
    assign rd_addr = rd_en_s ? quad_addr_s : {ADDR_W{1'b0}};

    assign sum_ld  = sum_ld_r;
    assign sum_acc = sum_acc_r;
    assign div_go  = div_go_r;
    assign q_sel   = q_sel_r;
    assign bin_sel = bin_sel_r;
    assign o_valid = pipe_valid_r[PIPE_LAT-1];
    assign o_last  = pipe_last_r[PIPE_LAT-1];

    // Select the line-buffer address of the quad currently being read.
    always_comb begin
        quad_addr_s = blk_addr_r;
        case (q_r)
            2'd0:    quad_addr_s = addr_back(blk_addr_r, OFF_TL);
            2'd1:    quad_addr_s = addr_back(blk_addr_r, OFF_TR);
            2'd2:    quad_addr_s = addr_back(blk_addr_r, OFF_BL);
            2'd3:    quad_addr_s = blk_addr_r;
            default: quad_addr_s = blk_addr_r;
        endcase
    end

    // Next-state and quad/bin step logic: 4 sum reads, then 36 quad-major feature reads.
    always_comb begin
        state_n = state_r;
        q_n     = q_r;
        bin_n   = bin_r;
        case (state_r)
            ST_IDLE: begin
                q_n   = 2'd0;
                bin_n = 4'd0;
                if (accept_s && block_s) begin
                    state_n = ST_SUM;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SUM: begin
                bin_n = 4'd0;
                if (q_r == 2'd3) begin
                    state_n = ST_FEAT;
                    q_n     = 2'd0;
                end else begin
                    state_n = ST_SUM;
                    q_n     = q_r + 2'd1;
                end
            end
            ST_FEAT: begin
                if (bin_r == BIN_LAST) begin
                    bin_n = 4'd0;
                    if (q_r == 2'd3) begin
                        state_n = ST_IDLE;
                        q_n     = 2'd0;
                    end else begin
                        state_n = ST_FEAT;
                        q_n     = q_r + 2'd1;
                    end
                end else begin
                    state_n = ST_FEAT;
                    bin_n   = bin_r + 4'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                q_n     = 2'd0;
                bin_n   = 4'd0;
            end
        endcase
    end

    // FSM state and step counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            q_r     <= 2'd0;
            bin_r   <= 4'd0;
        end else begin
            state_r <= state_n;
            q_r     <= q_n;
            bin_r   <= bin_n;
        end
    end

    // Frame position (cell index, column) and write pointer, advanced per accepted cell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_r   <= {C_W{1'b0}};
            col_r <= {COL_W{1'b0}};
            wp_r  <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            c_r   <= (c_eff_s == C_LAST) ? {C_W{1'b0}} : c_eff_s + C_W'(1);
            col_r <= (col_eff_s == COL_LAST) ? {COL_W{1'b0}} : col_eff_s + COL_W'(1);
            wp_r  <= (a_eff_s == WP_LAST) ? {ADDR_W{1'b0}} : a_eff_s + ADDR_W'(1);
        end else begin
            c_r   <= c_r;
            col_r <= col_r;
            wp_r  <= wp_r;
        end
    end

    // Block context captured at acceptance: BR address and whether it closes the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_addr_r <= {ADDR_W{1'b0}};
            blk_last_r <= 1'b0;
        end else if (accept_s && block_s) begin
            blk_addr_r <= a_eff_s;
            blk_last_r <= (c_eff_s == C_LAST);
        end else begin
            blk_addr_r <= blk_addr_r;
            blk_last_r <= blk_last_r;
        end
    end

    // Datapath strobes registered one cycle after the read to align with RAM data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_ld_r   <= 1'b0;
            sum_acc_r  <= 1'b0;
            div_go_r   <= 1'b0;
            q_sel_r    <= 2'd0;
            bin_sel_r  <= 4'd0;
            last_tag_r <= 1'b0;
        end else begin
            sum_ld_r   <= (state_r == ST_SUM) && (q_r == 2'd0);
            sum_acc_r  <= (state_r == ST_SUM) && (q_r != 2'd0);
            div_go_r   <= (state_r == ST_FEAT);
            q_sel_r    <= rd_en_s ? q_r : 2'd0;
            bin_sel_r  <= (state_r == ST_FEAT) ? bin_r : 4'd0;
            last_tag_r <= (state_r == ST_FEAT) && blk_last_r &&
                          (q_r == 2'd3) && (bin_r == BIN_LAST);
        end
    end

    // Delay line matching the div+sqrt pipeline for feature valid and frame-end tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid_r <= {PIPE_LAT{1'b0}};
            pipe_last_r  <= {PIPE_LAT{1'b0}};
        end else begin
            pipe_valid_r <= {pipe_valid_r[PIPE_LAT-2:0], div_go_r};
            pipe_last_r  <= {pipe_last_r[PIPE_LAT-2:0], last_tag_r};
        end
    end

endmodule

// File: tb/tb_norm_block_scheduler.sv
module tb_norm_block_scheduler;

    localparam int LINE     = 40;
    localparam int CELL_NUM = 1200;
    localparam int DEPTH    = 42;
    localparam int ADDR_W   = 6;
    localparam int PIPE_LAT = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              cell_valid;
    logic              cell_sof;
    logic              cell_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              sum_ld;
    logic              sum_acc;
    logic              div_go;
    logic [1:0]        q_sel;
    logic [3:0]        bin_sel;
    logic              o_valid;
    logic              o_last;

    norm_block_scheduler #(
        .LINE(LINE), .CELL_NUM(CELL_NUM), .DEPTH(DEPTH),
        .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .cell_valid(cell_valid), .cell_sof(cell_sof), .cell_ready(cell_ready),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .sum_ld(sum_ld), .sum_acc(sum_acc), .div_go(div_go),
        .q_sel(q_sel), .bin_sel(bin_sel),
        .o_valid(o_valid), .o_last(o_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected event: cycle t, fields a/b/c depend on the queue
    typedef struct {
        int t;
        int a;
        int b;
        int c;
    } ev_t;

    ev_t q_wr[$];   // a = write address
    ev_t q_rd[$];   // a = read address
    ev_t q_sum[$];  // a = 1 for load, 0 for accumulate
    ev_t q_div[$];  // a = quad, b = bin
    ev_t q_ov[$];   // a = last flag

    int n_chk = 0;
    int n_fail = 0;
    int ov_cnt = 0;
    int last_cnt = 0;

    // reference model state
    int m_c = 0;
    int m_wp = 0;
    int busy_until = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one accepted cell and everything it should cause later.
    task automatic model_accept(input logic s);
        int t;
        int ce;
        int a;
        int qa[4];
        int idx;
        t  = cyc;
        ce = s ? 0 : m_c;
        a  = s ? 0 : m_wp;
        q_wr.push_back('{t, a, 0, 0});
        if (ce >= LINE && (ce % LINE) != 0) begin
            qa[0] = (a + DEPTH - LINE - 1) % DEPTH;
            qa[1] = (a + DEPTH - LINE) % DEPTH;
            qa[2] = (a + DEPTH - 1) % DEPTH;
            qa[3] = a;
            for (int q = 0; q < 4; q++) begin
                q_rd.push_back('{t + 1 + q, qa[q], 0, 0});
                q_sum.push_back('{t + 2 + q, (q == 0) ? 1 : 0, 0, 0});
            end
            for (int q = 0; q < 4; q++) begin
                for (int b = 0; b < 9; b++) begin
                    idx = q * 9 + b;
                    q_rd.push_back('{t + 5 + idx, qa[q], 0, 0});
                    q_div.push_back('{t + 6 + idx, q, b, 0});
                    q_ov.push_back('{t + 6 + PIPE_LAT + idx,
                                     (ce == CELL_NUM - 1 && q == 3 && b == 8) ? 1 : 0, 0, 0});
                end
            end
            busy_until = t + 41;
        end
        m_c  = (ce + 1) % CELL_NUM;
        m_wp = (a + 1) % DEPTH;
    endtask

    // One clock of stimulus; called at posedge+1.
    task automatic step(input logic v, input logic s, output logic acc);
        cell_valid = v;
        cell_sof   = s;
        acc        = 1'b0;
        chk("cell_ready", int'(cell_ready), (cyc >= busy_until) ? 1 : 0);
        if (v && cyc >= busy_until) begin
            model_accept(s);
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input bit random_gaps, input bit sof_first);
        int done;
        logic acc;
        logic v;
        done = 0;
        while (done < n) begin
            v = random_gaps ? ($urandom_range(0, 7) != 0) : 1'b1;
            step(v, sof_first && (done == 0), acc);
            if (acc) done++;
        end
    endtask

    task automatic drain();
        int k;
        logic acc;
        k = 0;
        while ((q_wr.size() + q_rd.size() + q_sum.size() + q_div.size() + q_ov.size()) != 0
               && k < 200) begin
            step(1'b0, 1'b0, acc);
            k++;
        end
        chk("drain_left", q_wr.size() + q_rd.size() + q_sum.size() + q_div.size() + q_ov.size(), 0);
    endtask

    // Monitor: pops expected events whenever the DUT presents an output.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            chk("rst_outputs", int'({rd_en, sum_ld, sum_acc, div_go, o_valid, o_last}), 0);
        end else begin
            if (wr_en) begin
                if (q_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = q_wr.pop_front();
                    chk("wr_cycle", cyc, e.t);
                    chk("wr_addr", int'(wr_addr), e.a);
                end
            end
            if (rd_en) begin
                if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e = q_rd.pop_front();
                    chk("rd_cycle", cyc, e.t);
                    chk("rd_addr", int'(rd_addr), e.a);
                end
            end
            if (sum_ld || sum_acc) begin
                if (q_sum.size() == 0) chk("sum_unexpected", 1, 0);
                else begin
                    e = q_sum.pop_front();
                    chk("sum_cycle", cyc, e.t);
                    chk("sum_ld", int'(sum_ld), e.a);
                    chk("sum_acc", int'(sum_acc), 1 - e.a);
                end
            end
            if (div_go) begin
                if (q_div.size() == 0) chk("div_unexpected", 1, 0);
                else begin
                    e = q_div.pop_front();
                    chk("div_cycle", cyc, e.t);
                    chk("q_sel", int'(q_sel), e.a);
                    chk("bin_sel", int'(bin_sel), e.b);
                end
            end
            if (o_valid) begin
                ov_cnt++;
                if (o_last) last_cnt++;
                if (q_ov.size() == 0) chk("o_valid_unexpected", 1, 0);
                else begin
                    e = q_ov.pop_front();
                    chk("o_valid_cycle", cyc, e.t);
                    chk("o_last", int'(o_last), e.a);
                end
            end
            if (o_last && !o_valid) chk("o_last_without_valid", 1, 0);
        end
    end

    initial begin
        int ov_before;
        logic acc;
        rst        = 1'b0;
        cell_valid = 1'b0;
        cell_sof   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cell_ready", int'(cell_ready), 1);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_wr_addr", int'(wr_addr), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        chk("reset_q_sel", int'(q_sel), 0);
        chk("reset_bin_sel", int'(bin_sel), 0);
        chk("reset_o_valid", int'(o_valid), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1: cells 0..40 back-to-back, 41/42 with valid held, rest with random gaps.
        send(41, 1'b0, 1'b1);
        send(2, 1'b0, 1'b0);
        send(CELL_NUM - 43, 1'b1, 1'b0);
        drain();
        chk("frame_o_valid_count", ov_cnt, (LINE - 1) * (CELL_NUM / LINE - 1) * 36);
        chk("frame_o_last_count", last_cnt, 1);

        // Next frame continues without sof, then a mid-frame sof.
        send(50, 1'b1, 1'b0);
        send(1, 1'b0, 1'b1);
        send(41, 1'b0, 1'b0);
        // Last cell sent closes a block; go into its FEAT phase with o_valid active.
        repeat (24) step(1'b0, 1'b0, acc);
        chk("pre_reset_o_valid", int'(o_valid), 1);
        rst = 1'b0;
        q_wr.delete();
        q_rd.delete();
        q_sum.delete();
        q_div.delete();
        q_ov.delete();
        #1;
        chk("reset_drop_o_valid", int'(o_valid), 0);
        chk("reset_drop_rd_en", int'(rd_en), 0);
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b1;
        m_c        = 0;
        m_wp       = 0;
        busy_until = 0;
        ov_before  = ov_cnt;
        repeat (60) step(1'b0, 1'b0, acc);
        chk("no_o_valid_after_reset", ov_cnt, ov_before);
        send(3, 1'b1, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
